// File: rtl/alu_4bit.sv
// Single-cycle registered 4-bit unsigned ALU: add, sub, mul, logic ops and division.
// Outputs update only on accepted operations; out_valid pulses for one cycle per result.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] opcode,
  output logic [3:0] result,
  output logic [3:0] remainder,
  output logic       zeroFlag,
  output logic       overflowFlag,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_DIV = 3'b111
  } op_e;

  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [7:0] prod8;

  assign sum5  = {1'b0, A} + {1'b0, B};
  assign diff5 = {1'b0, A} - {1'b0, B};
  assign prod8 = {4'b0000, A} * {4'b0000, B};

  // Restoring divider, one stage per dividend bit (MSB first). Each stage keeps
  // the partial remainder below B, so a successful subtraction always fits 4 bits.
  logic [3:0] div_rem_s [0:4];
  logic [3:0] div_quo;

  assign div_rem_s[0] = 4'b0000;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_div_stage
      logic [4:0] trial;
      logic [4:0] sub;
      assign trial            = {div_rem_s[gi], A[3-gi]};
      assign sub              = trial - {1'b0, B};
      assign div_quo[3-gi]    = ~sub[4];
      assign div_rem_s[gi+1]  = sub[4] ? trial[3:0] : sub[3:0];
    end
  endgenerate

  logic [3:0] alu_res;
  logic [3:0] alu_rem;
  logic       alu_ovf;

  always_comb begin
    alu_res = 4'b0000;
    alu_rem = 4'b0000;
    alu_ovf = 1'b0;
    case (op_e'(opcode))
      OP_ADD: begin
        alu_res = sum5[3:0];
        alu_ovf = sum5[4];
      end
      OP_SUB: begin
        alu_res = diff5[3:0];
        alu_ovf = diff5[4];
      end
      OP_MUL: begin
        alu_res = prod8[3:0];
        alu_rem = prod8[7:4];
        alu_ovf = |prod8[7:4];
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      OP_DIV: begin
        if (B == 4'b0000) begin
          alu_res = 4'b1111;
          alu_rem = A;
          alu_ovf = 1'b1;
        end else begin
          alu_res = div_quo;
          alu_rem = div_rem_s[4];
        end
      end
      default: ;
    endcase
  end

  logic [3:0] result_q, result_d;
  logic [3:0] remainder_q, remainder_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;
  logic       out_valid_q, out_valid_d;

  always_comb begin
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = alu_res;
      remainder_d = alu_rem;
      zero_d      = (alu_res == 4'b0000);
      ovf_d       = alu_ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 4'b0000;
      remainder_q <= 4'b0000;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result       = result_q;
  assign remainder    = remainder_q;
  assign zeroFlag     = zero_q;
  assign overflowFlag = ovf_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed + exhaustive-division bench for alu_4bit with a queue scoreboard
// fed from a behavioural reference model.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opcode;
  logic [3:0] result;
  logic [3:0] remainder;
  logic       zeroFlag;
  logic       overflowFlag;
  logic       out_valid;

  alu_4bit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .A            (A),
    .B            (B),
    .opcode       (opcode),
    .result       (result),
    .remainder    (remainder),
    .zeroFlag     (zeroFlag),
    .overflowFlag (overflowFlag),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] rem;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   ai, bi, t;
    ai = int'(a);
    bi = int'(b);
    e = '0;
    case (op)
      3'd0: begin t = ai + bi; e.res = 4'(t % 16); e.ovf = (t > 15); end
      3'd1: begin t = ai - bi + 16; e.res = 4'(t % 16); e.ovf = (ai < bi); end
      3'd2: begin t = ai * bi; e.res = 4'(t % 16); e.rem = 4'(t / 16); e.ovf = (t > 15); end
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: e.res = ~a;
      default: begin
        if (bi == 0) begin e.res = 4'hF; e.rem = a; e.ovf = 1'b1; end
        else begin e.res = 4'(ai / bi); e.rem = 4'(ai % bi); end
      end
    endcase
    e.zero = (e.res == 4'h0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e, input logic vld);
    chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, vld});
    chk({tag, ".result"}, result, e.res);
    chk({tag, ".remainder"}, remainder, e.rem);
    chk({tag, ".zeroFlag"}, {3'b000, zeroFlag}, {3'b000, e.zero});
    chk({tag, ".overflowFlag"}, {3'b000, overflowFlag}, {3'b000, e.ovf});
  endtask

  // Present one operation; the result must appear one edge later.
  task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed empty expected entry");
    end else begin
      e = exp_q.pop_front();
      chk_outputs("op", e, 1'b1);
      last_exp = e;
    end
    $display("txn op=%b A=%b B=%b -> result=%b rem=%b z=%b ovf=%b vld=%b",
             op, a, b, result, remainder, zeroFlag, overflowFlag, out_valid);
  endtask

  task automatic do_idle();
    in_valid = 1'b0;
    A        = 4'hA;
    B        = 4'h5;
    opcode   = 3'd0;
    @(posedge clk);
    #1;
    chk_outputs("idle", last_exp, 1'b0);
    $display("txn idle -> result=%b rem=%b z=%b ovf=%b vld=%b",
             result, remainder, zeroFlag, overflowFlag, out_valid);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 4'h0;
    B        = 4'h0;
    opcode   = 3'd0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", '0, 1'b0);
    $display("txn reset -> result=%b vld=%b", result, out_valid);
    rst = 1'b0;

    // Directed vectors, issued back to back.
    do_op(3'd0, 4'b1001, 4'b0110);
    do_op(3'd0, 4'b1010, 4'b0011);
    do_op(3'd0, 4'b1000, 4'b1000);
    do_op(3'd1, 4'b1001, 4'b0110);
    do_op(3'd1, 4'b1000, 4'b0010);
    do_op(3'd1, 4'b0010, 4'b0011);
    do_op(3'd2, 4'b1001, 4'b0110);
    do_op(3'd2, 4'b0011, 4'b0010);
    do_op(3'd2, 4'b1000, 4'b0010);
    do_op(3'd7, 4'b1001, 4'b0110);
    do_op(3'd7, 4'b1010, 4'b0011);
    do_op(3'd7, 4'b1000, 4'b0010);
    do_op(3'd7, 4'b0101, 4'b0000);
    do_op(3'd7, 4'b0000, 4'b0000);
    do_op(3'd3, 4'b1100, 4'b1010);
    do_op(3'd4, 4'b1100, 4'b1010);
    do_op(3'd5, 4'b1100, 4'b1010);
    do_op(3'd6, 4'b1100, 4'b0000);
    do_op(3'd6, 4'b1111, 4'b0101);

    // Hold behaviour with in_valid low.
    do_idle();
    do_idle();

    // Reset wins over a simultaneous operation.
    rst      = 1'b1;
    in_valid = 1'b1;
    opcode   = 3'd2;
    A        = 4'b1111;
    B        = 4'b1111;
    @(posedge clk);
    #1;
    last_exp = '0;
    chk_outputs("rst_with_valid", '0, 1'b0);
    $display("txn rst+valid -> result=%b vld=%b", result, out_valid);
    rst = 1'b0;
    do_op(3'd0, 4'b0111, 4'b0001);

    // Every division operand pair.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(3'd7, 4'(a), 4'(b));

    // Random mix across all opcodes, with occasional idle cycles.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) do_idle();
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    do_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
